// File: rtl/eth_rx_slot_writer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eth_rx_slot_writer_if : MAC rx stream, frame-buffer port A and host status
// Rev 1.0
// ----------------------------------------------------------------------------
interface eth_rx_slot_writer_if #(
  parameter int SLOT_BITS    = 3,
  parameter int SLOT_HW_BITS = 10,
  parameter int AW           = 13,
  parameter int LW           = 12
);
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_sof;
  logic                 rx_eof;
  logic                 rx_err;
  logic [AW-1:0]        mem_addr;
  logic [15:0]          mem_din;
  logic [1:0]           mem_we;
  logic                 mem_en;
  logic                 host_consume;
  logic                 frm_avail;
  logic [SLOT_BITS:0]   frm_count;
  logic [SLOT_BITS-1:0] frm_slot;
  logic [LW-1:0]        frm_len;
  logic [15:0]          drop_cnt;

  modport master (
    output rx_data, rx_valid, rx_sof, rx_eof, rx_err, host_consume,
    input  mem_addr, mem_din, mem_we, mem_en,
    input  frm_avail, frm_count, frm_slot, frm_len, drop_cnt
  );

  modport slave (
    input  rx_data, rx_valid, rx_sof, rx_eof, rx_err, host_consume,
    output mem_addr, mem_din, mem_we, mem_en,
    output frm_avail, frm_count, frm_slot, frm_len, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/eth_rx_slot_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eth_rx_slot_writer : writes rx bytes into a ring of frame-buffer slots
// Rev 1.0
// ----------------------------------------------------------------------------
module eth_rx_slot_writer #(
  parameter int SLOT_BITS    = 3,
  parameter int SLOT_HW_BITS = 10,
  parameter int AW           = 13,
  parameter int LW           = 12
) (
  input  wire logic          clk,
  input  wire logic          rst,
  eth_rx_slot_writer_if.slave bus
);

  localparam logic [1:0]    S_IDLE     = 2'd0;
  localparam logic [1:0]    S_RECV     = 2'd1;
  localparam logic [1:0]    S_DROP     = 2'd2;
  localparam int            NSLOT      = 1 << SLOT_BITS;
  localparam int            CW         = SLOT_BITS + 1;
  localparam logic [LW-1:0] SLOT_BYTES = LW'(2 ** (SLOT_HW_BITS + 1));

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [SLOT_BITS-1:0] r_wr_slot;
  logic [SLOT_BITS-1:0] r_rd_slot;
  logic [LW-1:0]        r_byte_cnt;
  logic [CW-1:0]        r_frm_count;
  logic [LW-1:0]        r_len [NSLOT];
  logic [15:0]          r_drop_cnt;
  logic                 r_mem_en;
  logic [1:0]           r_mem_we;
  logic [AW-1:0]        r_mem_addr;
  logic [15:0]          r_mem_din;

  logic                 w_full;
  logic                 w_slot_full;
  logic                 w_wr;
  logic                 w_commit;
  logic                 w_consume;
  logic [1:0]           w_drop_add;
  logic [LW-1:0]        w_pos;
  logic [LW-1:0]        w_cnt_nxt;
  logic [16:0]          w_drop_sum;

  assign w_full      = r_frm_count[SLOT_BITS];
  assign w_slot_full = (r_byte_cnt == SLOT_BYTES);
  assign w_consume   = bus.host_consume && (r_frm_count != '0);
  assign w_drop_sum  = {1'b0, r_drop_cnt} + 17'(w_drop_add);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DROP: begin
        if (bus.rx_valid) begin
          if (bus.rx_sof)
            w_state_nxt = bus.rx_eof ? S_IDLE : (w_full ? S_DROP : S_RECV);
          else if (bus.rx_eof && (r_state == S_DROP))
            w_state_nxt = S_IDLE;
        end
      end
      S_RECV: begin
        if (bus.rx_valid) begin
          if (bus.rx_eof)
            w_state_nxt = S_IDLE;
          else if (!bus.rx_sof && w_slot_full)
            w_state_nxt = S_DROP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // w_pos is the byte offset of the sampled byte inside the current slot
  always_comb begin
    w_wr       = 1'b0;
    w_commit   = 1'b0;
    w_drop_add = 2'd0;
    w_pos      = r_byte_cnt;
    w_cnt_nxt  = r_byte_cnt;
    case (r_state)
      S_IDLE, S_DROP: begin
        if (bus.rx_valid && bus.rx_sof) begin
          w_pos = '0;
          if (w_full) begin
            w_drop_add = 2'd1;
            w_cnt_nxt  = '0;
          end else begin
            w_wr      = 1'b1;
            w_cnt_nxt = LW'(1);
          end
        end
      end
      S_RECV: begin
        if (bus.rx_valid) begin
          if (bus.rx_sof) begin
            w_drop_add = 2'd1;
            w_pos      = '0;
            w_wr       = 1'b1;
            w_cnt_nxt  = LW'(1);
          end else if (w_slot_full) begin
            w_drop_add = 2'd1;
            w_cnt_nxt  = '0;
          end else begin
            w_wr      = 1'b1;
            w_cnt_nxt = r_byte_cnt + LW'(1);
          end
        end
      end
      default: ;
    endcase
    if (w_wr && bus.rx_eof) begin
      w_cnt_nxt = '0;
      if (bus.rx_err) w_drop_add = w_drop_add + 2'd1;
      else            w_commit   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_slot   <= '0;
      r_rd_slot   <= '0;
      r_byte_cnt  <= '0;
      r_frm_count <= '0;
      r_drop_cnt  <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 2'b00;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      for (int i = 0; i < NSLOT; i++) r_len[i] <= '0;
    end else begin
      r_byte_cnt <= w_cnt_nxt;
      r_mem_en   <= w_wr;
      r_mem_we   <= w_wr ? (w_pos[0] ? 2'b10 : 2'b01) : 2'b00;
      if (w_wr) begin
        r_mem_addr <= {r_wr_slot, w_pos[LW-2:1]};
        r_mem_din  <= {bus.rx_data, bus.rx_data};
      end
      if (w_commit) begin
        r_len[r_wr_slot] <= w_pos + LW'(1);
        r_wr_slot        <= r_wr_slot + SLOT_BITS'(1);
      end
      if (w_consume) r_rd_slot <= r_rd_slot + SLOT_BITS'(1);
      case ({w_commit, w_consume})
        2'b10:   r_frm_count <= r_frm_count + CW'(1);
        2'b01:   r_frm_count <= r_frm_count - CW'(1);
        default: r_frm_count <= r_frm_count;
      endcase
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_din   = r_mem_din;
  assign bus.frm_count = r_frm_count;
  assign bus.frm_avail = (r_frm_count != '0);
  assign bus.frm_slot  = r_rd_slot;
  assign bus.frm_len   = (r_frm_count != '0) ? r_len[r_rd_slot] : '0;
  assign bus.drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire
